c_stream_drain: RTL and testbench



---
 rtl/c_stream_drain_pkg.sv | 29 ++
 rtl/stream_fifo.sv | 61 ++++++
 rtl/c_stream_drain.sv | 152 +++++++++++++++
 tb/tb_c_stream_drain.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c_stream_drain_pkg.sv
// ============================================================================
//  Module   : c_stream_drain_pkg
//  Purpose  : Shared types and constants for the C-out drain path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package c_stream_drain_pkg;

    localparam int DRAIN_BURST_LEN  = 16;
    localparam int DRAIN_FIFO_DEPTH = 4;
    localparam int DRAIN_ADDR_WIDTH = 32;
    localparam int DRAIN_LEN_WIDTH  = 16;

    typedef struct packed {
        logic [DRAIN_ADDR_WIDTH-1:0] addr;
        logic [DRAIN_LEN_WIDTH-1:0]  beats;
    } DrainCmd;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/stream_fifo.sv
// ============================================================================
//  Module   : stream_fifo
//  Purpose  : Registered FIFO with head output; push refused when full.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/c_stream_drain.sv
// ============================================================================
//  Module   : c_stream_drain
//  Purpose  : Drains the accelerator result stream into segmented burst writes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module c_stream_drain
    import c_stream_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST_LEN  = DRAIN_BURST_LEN,
    parameter int FIFO_DEPTH = DRAIN_FIFO_DEPTH,
    localparam int BLW       = $clog2(BURST_LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  wr_req_valid,
    input  logic                  wr_req_ready,
    output logic [ADDR_WIDTH-1:0] wr_req_addr,
    output logic [BLW-1:0]        wr_req_len,
    output logic                  wr_data_valid,
    input  logic                  wr_data_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_data_last,
    output logic                  busy,
    output logic                  done
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;

    drain_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  rem_in_q, rem_in_d;
    logic [LEN_WIDTH-1:0]  rem_out_q, rem_out_d;
    logic [BLW-1:0]        burst_cnt_q, burst_cnt_d;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [BLW-1:0]        req_len;

    assign busy      = (state_q != IDLE);
    // Upstream acceptance depends only on registered state, never on the write side.
    assign in_ready  = busy && (rem_in_q != '0) && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign req_len   = (rem_out_q >= LEN_WIDTH'(BURST_LEN)) ? BLW'(BURST_LEN)
                                                           : rem_out_q[BLW-1:0];
    assign wr_data   = wr_data_valid ? fifo_head : '0;

    stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        rem_in_d      = rem_in_q;
        rem_out_d     = rem_out_q;
        burst_cnt_d   = burst_cnt_q;
        cmd_ready     = 1'b0;
        wr_req_valid  = 1'b0;
        wr_req_addr   = '0;
        wr_req_len    = '0;
        wr_data_valid = 1'b0;
        wr_data_last  = 1'b0;
        fifo_pop      = 1'b0;
        done          = 1'b0;

        if (fifo_push) rem_in_d = rem_in_q - LEN_WIDTH'(1);

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    rem_in_d   = cmd_beats;
                    rem_out_d  = cmd_beats;
                    state_d    = (cmd_beats != '0) ? REQ : FIN;
                end
            end
            REQ: begin
                wr_req_valid = 1'b1;
                wr_req_addr  = cur_addr_q;
                wr_req_len   = req_len;
                if (wr_req_ready) begin
                    burst_cnt_d = req_len;
                    cur_addr_d  = cur_addr_q +
                                  ADDR_WIDTH'(req_len) * ADDR_WIDTH'(BEAT_BYTES);
                    state_d     = DATA;
                end
            end
            DATA: begin
                wr_data_valid = !fifo_empty;
                wr_data_last  = (burst_cnt_q == BLW'(1));
                if (wr_data_valid && wr_data_ready) begin
                    fifo_pop    = 1'b1;
                    burst_cnt_d = burst_cnt_q - BLW'(1);
                    rem_out_d   = rem_out_q - LEN_WIDTH'(1);
                    if (wr_data_last) begin
                        state_d = (rem_out_q == LEN_WIDTH'(1)) ? FIN : REQ;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            rem_in_q    <= '0;
            rem_out_q   <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_in_q    <= rem_in_d;
            rem_out_q   <= rem_out_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_c_stream_drain.sv
// ============================================================================
//  Module   : tb_c_stream_drain
//  Purpose  : Randomised scoreboard bench for the C-out drain block.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_c_stream_drain;

    localparam int DW  = 512;
    localparam int AW  = 32;
    localparam int LW  = 16;
    localparam int BL  = 16;
    localparam int FD  = 4;
    localparam int BLW = $clog2(BL) + 1;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_beats;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [BLW-1:0] wr_req_len;
    logic          wr_data_valid;
    logic          wr_data_ready;
    logic [DW-1:0] wr_data;
    logic          wr_data_last;
    logic          busy;
    logic          done;

    c_stream_drain #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_beats     (cmd_beats),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_req_len    (wr_req_len),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .wr_data_last  (wr_data_last),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
    } req_t;

    req_t          exp_req[$];
    logic [DW-1:0] exp_data[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int burst_rem = 0;
    int in_cnt = 0;
    int cur_beats = 0;
    int wr_cnt = 0;
    int last_beat_cyc = 0;
    int hs_cyc = 0;
    bit saw_stall = 0;
    bit pend = 0;
    logic [AW+BLW:0] pend_val;
    int up_p = 100;
    int wreq_p = 100;
    int wdat_p = 100;
    int wmode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] s);
        return {16{s}};
    endfunction

    // Upstream source: an endless incrementing stream, advanced only on acceptance.
    initial begin
        bit          take;
        logic [31:0] seq;
        seq      = 32'h100;
        in_valid = 1'b0;
        in_data  = pat(seq);
        forever begin
            @(negedge clk);
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take && !rst) begin
                exp_data.push_back(in_data);
                in_cnt++;
                seq++;
            end
            in_valid = ($urandom_range(0, 99) < up_p);
            in_data  = pat(seq);
        end
    end

    // Write-side responder.
    initial begin
        int req_wait;
        req_wait      = 0;
        wr_req_ready  = 1'b0;
        wr_data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (wmode == 0) begin
                wr_req_ready  = ($urandom_range(0, 99) < wreq_p);
                wr_data_ready = ($urandom_range(0, 99) < wdat_p);
            end else begin
                req_wait      = wr_req_valid ? req_wait + 1 : 0;
                wr_req_ready  = (req_wait > 5);
                wr_data_ready = ~wr_data_ready;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake.
    initial begin
        req_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pend) chk("req_hold", {wr_req_valid, wr_req_addr, wr_req_len}, pend_val);
                pend     = wr_req_valid && !wr_req_ready;
                pend_val = {wr_req_valid, wr_req_addr, wr_req_len};
                if (wr_req_valid && wr_req_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", wr_req_valid, 1'b0);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_addr", wr_req_addr, r.addr);
                        chk("req_len", wr_req_len, r.len);
                        burst_rem = r.len;
                    end
                end
                if (wr_data_valid && wr_data_ready) begin
                    if (exp_data.size() == 0) chk("data_unexpected", wr_data_valid, 1'b0);
                    else chk("wr_data", wr_data, exp_data.pop_front());
                    chk("wr_last", wr_data_last, burst_rem == 1);
                    burst_rem--;
                    wr_cnt++;
                    last_beat_cyc = cyc;
                end
                if (busy && !in_ready && in_cnt < cur_beats) saw_stall = 1;
                if (done) begin
                    chk("done_in_count", in_cnt, cur_beats);
                    chk("done_req_left", exp_req.size(), 0);
                    chk("done_data_left", exp_data.size(), 0);
                    if (cur_beats != 0) chk("done_latency", cyc - last_beat_cyc, 1);
                    else chk("zero_done_latency", (cyc - hs_cyc) <= 2, 1'b1);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_req_valid"}, {wr_req_valid, wr_req_addr, wr_req_len}, '0);
        chk({tag, "_data_out"}, {wr_data_valid, wr_data_last, done}, '0);
        chk({tag, "_wr_data"}, wr_data, '0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        @(posedge clk);
        #2;
        exp_req.delete();
        exp_data.delete();
        burst_rem = 0;
        pend      = 0;
        in_cnt    = 0;
        cur_beats = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue_cmd(input logic [AW-1:0] addr, input int beats);
        logic [AW-1:0] a;
        int            rem;
        int            l;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        @(posedge clk);
        #1;
        a   = addr;
        rem = beats;
        while (rem > 0) begin
            l = (rem > BL) ? BL : rem;
            exp_req.push_back('{a, l});
            a   = a + AW'(l * (DW / 8));
            rem = rem - l;
        end
        cur_beats = beats;
        in_cnt    = 0;
        saw_stall = 0;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_beats = LW'(beats);
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1'b1);
        hs_cyc = cyc;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk({tag, "_done_timeout"}, done, 1'b1);
            do_reset({tag, "_recover"});
        end else begin
            @(negedge clk);
            chk({tag, "_busy_after_done"}, busy, 1'b0);
            chk({tag, "_in_ready_after_done"}, in_ready, 1'b0);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [AW-1:0] addr, input int beats);
        issue_cmd(addr, beats);
        wait_done(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int base;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        run_cmd("single", 32'h1000, 3);
        run_cmd("multi", 32'h0, 40);

        wmode = 1;
        issue_cmd(32'h2000, 20);
        wait_done("bp");
        chk("bp_in_ready_drop", saw_stall, 1'b1);
        wmode = 0;

        run_cmd("zero", 32'h3000, 0);
        run_cmd("excess_a", 32'h4000, 8);
        run_cmd("excess_b", 32'h5000, 4);
        run_cmd("wrap", 32'hFFFF_FE00, 20);

        base = wr_cnt;
        issue_cmd(32'h7000, 16);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (wr_cnt >= base + 4) break;
        end
        chk("midreset_reached_beat5", wr_cnt - base, 4);
        do_reset("midreset");
        run_cmd("after_reset", 32'h6000, 2);

        for (int i = 0; i < 12; i++) begin
            up_p   = $urandom_range(30, 100);
            wreq_p = $urandom_range(30, 100);
            wdat_p = $urandom_range(30, 100);
            run_cmd("random", {$urandom_range(0, 32'h03FF_FFFF), 6'b0},
                    ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 50));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
